// File: rtl/snn_frame_sequencer.sv
// Chunked image loader and run sequencer for the spiking network: assembles the
// pixel vector from host word chunks, starts/clock-enables the network, latches the result.
module snn_frame_sequencer #(
  parameter int WORD_W          = 32,
  parameter int WORDS_PER_CHUNK = 14,
  parameter int NUM_CHUNKS      = 2,
  parameter int IMG_BITS        = 800,
  parameter int OUT_W           = 2,
  parameter int RUN_TIMEOUT     = 1024
) (
  input  logic                                iCLK,
  input  logic                                iRESET,
  input  logic [WORD_W*WORDS_PER_CHUNK-1:0]   iWORDS,
  input  logic                                iNEXT,
  input  logic                                iFINISH,
  input  logic                                iSNN_DONE,
  input  logic [OUT_W-1:0]                    iSNN_RESULT,
  input  logic                                iRESULT_ACK,
  output logic [IMG_BITS-1:0]                 oIMAGE,
  output logic                                oSNN_START,
  output logic                                oSNN_CE,
  output logic [OUT_W-1:0]                    oRESULT,
  output logic                                oRESULT_VALID,
  output logic                                oBUSY,
  output logic [$clog2(NUM_CHUNKS+1)-1:0]     oCHUNK_IDX,
  output logic                                oERR,
  output logic                                oTIMEOUT
);
  localparam int CHUNK_BITS = WORD_W * WORDS_PER_CHUNK;
  localparam int IDX_W      = $clog2(NUM_CHUNKS + 1);
  localparam int CNT_W      = $clog2(RUN_TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DONE} state_t;

  state_t              r_state;
  logic                r_next_q;
  logic [IMG_BITS-1:0] r_image;
  logic                r_start;
  logic                r_ce;
  logic [OUT_W-1:0]    r_result;
  logic                r_valid;
  logic [IDX_W-1:0]    r_chunk_idx;
  logic                r_err;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_nedge;
  logic                w_wr;
  logic [IDX_W-1:0]    w_c;
  logic                w_last_chunk;
  logic                w_timeout_hit;
  logic [IMG_BITS-1:0] w_img_next;

  assign w_nedge       = iNEXT & ~r_next_q;
  assign w_wr          = w_nedge & ((r_state == S_IDLE) | (r_state == S_LOAD) | (r_state == S_DONE));
  // A write from DONE always opens a new frame, whatever the stale index says.
  assign w_c           = (r_state == S_DONE) ? '0 : r_chunk_idx;
  assign w_last_chunk  = (w_c == IDX_W'(NUM_CHUNKS - 1));
  assign w_timeout_hit = (r_cnt == CNT_W'(RUN_TIMEOUT - 1));

  // Chunk c lands at c*CHUNK_BITS; chunk 0 also wipes the rest of the previous frame.
  always_comb begin
    w_img_next = r_image;
    for (int i = 0; i < IMG_BITS; i++) begin
      if (int'(w_c) == i / CHUNK_BITS) w_img_next[i] = iWORDS[i % CHUNK_BITS];
      else if (w_c == '0)              w_img_next[i] = 1'b0;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state     <= S_IDLE;
      r_next_q    <= 1'b0;
      r_image     <= '0;
      r_start     <= 1'b0;
      r_ce        <= 1'b0;
      r_result    <= '0;
      r_valid     <= 1'b0;
      r_chunk_idx <= '0;
      r_err       <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_next_q <= iNEXT;
      case (r_state)
        S_IDLE, S_LOAD, S_DONE: begin
          if (w_wr) begin
            r_image     <= w_img_next;
            r_chunk_idx <= w_c + 1'b1;
            r_valid     <= 1'b0;
            if (w_c == '0) r_err <= 1'b0;
            if (w_last_chunk && !iFINISH) r_err <= 1'b1;
            if (iFINISH || w_last_chunk) begin
              r_state <= S_START;
              r_start <= 1'b1;
            end else begin
              r_state <= S_LOAD;
            end
          end else if (r_state == S_DONE && iRESULT_ACK && r_valid) begin
            r_valid     <= 1'b0;
            r_chunk_idx <= '0;
            r_state     <= S_IDLE;
          end
        end
        S_START: begin
          r_start <= 1'b0;
          r_ce    <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_RUN;
          if (w_nedge) r_err <= 1'b1;
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_nedge) r_err <= 1'b1;
          // Timeout still captures whatever the network drives so the host never stalls.
          if (iSNN_DONE || w_timeout_hit) begin
            r_result  <= iSNN_RESULT;
            r_valid   <= 1'b1;
            r_timeout <= ~iSNN_DONE;
            r_ce      <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oIMAGE        = r_image;
  assign oSNN_START    = r_start;
  assign oSNN_CE       = r_ce;
  assign oRESULT       = r_result;
  assign oRESULT_VALID = r_valid;
  assign oBUSY         = (r_state != S_IDLE);
  assign oCHUNK_IDX    = r_chunk_idx;
  assign oERR          = r_err;
  assign oTIMEOUT      = r_timeout;
endmodule

// File: tb/tb_snn_frame_sequencer.sv
// Directed bench for snn_frame_sequencer: a full-size instance plus a 7-bit image
// instance sharing the same stimulus to exercise truncation.
module tb_snn_frame_sequencer;
  logic         iCLK = 1'b0;
  logic         iRESET;
  logic [447:0] iWORDS;
  logic         iNEXT, iFINISH, iSNN_DONE, iRESULT_ACK;
  logic [1:0]   iSNN_RESULT;

  logic [799:0] oIMAGE;
  logic         oSNN_START, oSNN_CE, oRESULT_VALID, oBUSY, oERR, oTIMEOUT;
  logic [1:0]   oRESULT, oCHUNK_IDX;

  logic [6:0]   s_image;
  logic         s_start, s_ce, s_valid, s_busy, s_err, s_timeout;
  logic [1:0]   s_result, s_idx;

  int n_checks = 0;
  int n_err    = 0;
  int n_ce;

  always #5 iCLK = ~iCLK;

  snn_frame_sequencer #(.RUN_TIMEOUT(16)) u_dut (
    .iCLK(iCLK), .iRESET(iRESET), .iWORDS(iWORDS), .iNEXT(iNEXT), .iFINISH(iFINISH),
    .iSNN_DONE(iSNN_DONE), .iSNN_RESULT(iSNN_RESULT), .iRESULT_ACK(iRESULT_ACK),
    .oIMAGE(oIMAGE), .oSNN_START(oSNN_START), .oSNN_CE(oSNN_CE), .oRESULT(oRESULT),
    .oRESULT_VALID(oRESULT_VALID), .oBUSY(oBUSY), .oCHUNK_IDX(oCHUNK_IDX),
    .oERR(oERR), .oTIMEOUT(oTIMEOUT));

  snn_frame_sequencer #(.IMG_BITS(7), .RUN_TIMEOUT(16)) u_small (
    .iCLK(iCLK), .iRESET(iRESET), .iWORDS(iWORDS), .iNEXT(iNEXT), .iFINISH(iFINISH),
    .iSNN_DONE(iSNN_DONE), .iSNN_RESULT(iSNN_RESULT), .iRESULT_ACK(iRESULT_ACK),
    .oIMAGE(s_image), .oSNN_START(s_start), .oSNN_CE(s_ce), .oRESULT(s_result),
    .oRESULT_VALID(s_valid), .oBUSY(s_busy), .oCHUNK_IDX(s_idx),
    .oERR(s_err), .oTIMEOUT(s_timeout));

  task automatic chk(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  // One idle-low cycle, then a single rising edge of iNEXT carrying the chunk.
  task automatic send_chunk(input logic [31:0] w, input logic fin);
    iNEXT = 1'b0;
    tick();
    iWORDS  = {14{w}};
    iFINISH = fin;
    iNEXT   = 1'b1;
    tick();
    iNEXT = 1'b0;
  endtask

  initial begin
    iRESET = 1'b1; iWORDS = '0; iNEXT = 1'b0; iFINISH = 1'b0;
    iSNN_DONE = 1'b0; iSNN_RESULT = 2'b00; iRESULT_ACK = 1'b0;
    tick(); tick();
    chk("rst_image", oIMAGE, '0);
    chk("rst_ctl", {oSNN_START, oSNN_CE, oRESULT_VALID, oBUSY, oERR, oTIMEOUT}, '0);
    chk("rst_idx", oCHUNK_IDX, 2'd0);
    iRESET = 1'b0;
    tick();

    // Two-chunk frame, network answers in its 5th RUN cycle
    send_chunk(32'hA5A5A5A5, 1'b0);
    chk("c0_image", oIMAGE, {352'b0, {14{32'hA5A5A5A5}}});
    chk("c0_idx_busy", {oCHUNK_IDX, oBUSY, oSNN_START}, {2'd1, 1'b1, 1'b0});
    chk("small_c0", s_image, 7'h25);
    send_chunk(32'hFFFFFFFF, 1'b1);
    chk("c1_image", oIMAGE, {{11{32'hFFFFFFFF}}, {14{32'hA5A5A5A5}}});
    chk("start_pulse", {oSNN_START, oSNN_CE, oCHUNK_IDX}, {1'b1, 1'b0, 2'd2});
    chk("small_c1", s_image, 7'h25);
    tick();
    chk("run_ce", {oSNN_START, oSNN_CE}, 2'b01);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("run_hold", {oSNN_CE, oRESULT_VALID}, 2'b10);
    end
    iSNN_DONE = 1'b1; iSNN_RESULT = 2'b10;
    tick();
    iSNN_DONE = 1'b0; iSNN_RESULT = 2'b00;
    chk("done_cap", {oRESULT, oRESULT_VALID, oTIMEOUT, oSNN_CE}, {2'b10, 1'b1, 1'b0, 1'b0});
    tick(); tick();
    chk("valid_held", {oRESULT_VALID, oBUSY}, 2'b11);
    iRESULT_ACK = 1'b1;
    tick();
    iRESULT_ACK = 1'b0;
    chk("ack_idle", {oRESULT_VALID, oBUSY, oCHUNK_IDX, oRESULT}, {1'b0, 1'b0, 2'd0, 2'b10});

    // Timeout: network never signals done
    send_chunk(32'h12345678, 1'b0);
    send_chunk(32'hFFFFFFFF, 1'b1);
    iSNN_RESULT = 2'b01;
    n_ce = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (oSNN_CE) n_ce++;
      if (oRESULT_VALID) break;
    end
    chk("timeout_cycles", n_ce, 16);
    chk("timeout_cap", {oRESULT_VALID, oTIMEOUT, oRESULT, oSNN_CE}, {1'b1, 1'b1, 2'b01, 1'b0});

    // New frame edge in DONE together with ACK: one write, stale chunk cleared
    iWORDS = {14{32'h0F0F0F0F}}; iFINISH = 1'b0; iNEXT = 1'b1; iRESULT_ACK = 1'b1;
    tick();
    iNEXT = 1'b0; iRESULT_ACK = 1'b0;
    chk("done_next_ctl", {oRESULT_VALID, oBUSY, oCHUNK_IDX}, {1'b0, 1'b1, 2'd1});
    chk("done_next_img", oIMAGE, {352'b0, {14{32'h0F0F0F0F}}});
    chk("small_done_next", s_image, 7'h0F);

    // Edge during RUN is an error and leaves the image alone
    send_chunk(32'hC3C3C3C3, 1'b1);
    tick();
    send_chunk(32'h00000000, 1'b0);
    chk("run_edge_err", {oERR, oSNN_CE}, 2'b11);
    chk("run_edge_img", oIMAGE, {{11{32'hC3C3C3C3}}, {14{32'h0F0F0F0F}}});
    iSNN_DONE = 1'b1; iSNN_RESULT = 2'b11;
    tick();
    iSNN_DONE = 1'b0;
    chk("done2_cap", {oRESULT, oRESULT_VALID, oTIMEOUT}, {2'b11, 1'b1, 1'b0});
    chk("err_sticky", oERR, 1'b1);

    // Next frame chunk 0 clears the error; a held-high NEXT writes once
    iWORDS = {14{32'h55555555}}; iFINISH = 1'b0; iNEXT = 1'b1;
    tick();
    chk("err_clear", {oERR, oCHUNK_IDX, oRESULT_VALID}, {1'b0, 2'd1, 1'b0});
    iWORDS = {14{32'hAAAAAAAA}};
    tick(); tick(); tick();
    chk("held_idx", {oCHUNK_IDX, oSNN_START}, {2'd1, 1'b0});
    chk("held_img", oIMAGE, {352'b0, {14{32'h55555555}}});
    iNEXT = 1'b0;

    // Last chunk without FINISH: still written, starts, flags error
    send_chunk(32'h11111111, 1'b0);
    chk("last_nofin", {oERR, oSNN_START, oCHUNK_IDX}, {1'b1, 1'b1, 2'd2});
    chk("last_nofin_img", oIMAGE, {{11{32'h11111111}}, {14{32'h55555555}}});

    // Asynchronous reset in the middle of RUN
    tick();
    chk("pre_rst_ce", oSNN_CE, 1'b1);
    iRESET = 1'b1;
    #1;
    chk("async_rst_ctl", {oSNN_START, oSNN_CE, oRESULT_VALID, oBUSY, oERR, oTIMEOUT}, '0);
    chk("async_rst_img", oIMAGE, '0);
    chk("async_rst_idx", {oCHUNK_IDX, oRESULT}, 4'd0);
    tick();
    iRESET = 1'b0;
    tick();
    chk("post_rst_idle", {oBUSY, oSNN_CE}, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
